pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/stall/flush sequencer for the 5-stage pipeline. Drives the write-enables of PC and IF/ID, the
//  bubble (control-zero) input of ID/EX, and the hold of EX/MEM; computes the EX-stage forwarding selects.
//  Resolves load-use hazards, data-memory wait states (req/ready handshake) and taken-branch flushes.
// PARAMETERS
//  FLUSH_DEPTH  2    bubble cycles inserted after a taken branch (1..7)
//  MEM_TIMEOUT  255  max MEM_WAIT cycles before abort (1..255)
//  CNT_W        32   width of perf counters (only with HAZ_PERF_CNT_EN)
// PORTS
//  clk            in   1      rising-edge clock, sole clock
//  rst_n          in   1      synchronous reset, active-low
//  id_rs_addr     in   5      Rs of instr in ID
//  id_rt_addr     in   5      Rt of instr in ID
//  id_uses_rt     in   1      ID instr reads Rt (R-type, sw, beq)
//  ex_mem_read    in   1      ID/EX MemRead (load in EX)
//  ex_rs_addr     in   5      ID/EX Rs address
//  ex_rt_addr     in   5      ID/EX Rt address
//  ex_branch_tkn  in   1      branch resolved taken in EX
//  mem_reg_write  in   1      EX/MEM RegWrite
//  mem_dst_addr   in   5      EX/MEM destination register
//  wb_reg_write   in   1      MEM/WB RegWrite
//  wb_dst_addr    in   5      MEM/WB destination register
//  dmem_req       in   1      MEM-stage access active (MemRead|MemWrite)
//  dmem_ready     in   1      data memory completes access this cycle
//  pc_write       out  1      1 = PC may update
//  ifid_write     out  1      1 = IF/ID may capture
//  ifid_flush     out  1      1 = IF/ID loads NOP
//  idex_bubble    out  1      1 = ID/EX loads all control fields 0
//  exmem_hold     out  1      1 = EX/MEM and MEM/WB keep contents
//  fwd_a          out  2      ALU-A select: 00 reg, 10 EX/MEM, 01 MEM/WB
//  fwd_b          out  2      ALU-B select, same encoding
//  mem_err        out  1      sticky: MEM_WAIT timed out; cleared only by reset
//  stall_cnt      out  CNT_W  cycles with pc_write=0 (feature-gated)
//  flush_cnt      out  CNT_W  taken-branch flush events (feature-gated)
// BEHAVIOUR
//  - FSM (registered): RUN=0, MEM_WAIT=1, FLUSH=2. Outputs decode combinationally from state+inputs.
//  - Reset (rst_n=0 at posedge): state=RUN, counters=0, mem_err=0; while rst_n=0 all outputs forced:
//    pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_hold=0, fwd_a=fwd_b=00.
//  - Priority in RUN, same cycle: mem-wait > branch flush > load-use > none.
//  - MEM wait: dmem_req=1 & dmem_ready=0 -> pc_write=ifid_write=0, exmem_hold=1, idex_bubble=0 (ID/EX
//    also frozen via ifid_write=0 gating upstream); next state MEM_WAIT, wait counter=1.
//    MEM_WAIT: same freeze; dmem_ready=1 -> RUN, freeze released same cycle. Counter reaches
//    MEM_TIMEOUT -> mem_err=1, RUN. dmem_ready=1 in RUN costs zero stall cycles.
//  - Branch: ex_branch_tkn=1 -> ifid_flush=1, idex_bubble=1, pc_write=1 this cycle; if FLUSH_DEPTH>1
//    go FLUSH, down-counter=FLUSH_DEPTH-1; FLUSH holds ifid_flush=idex_bubble=1 until counter 0 -> RUN.
//    ex_branch_tkn during FLUSH ignored (bubble). Mem-wait arriving in FLUSH: freeze; counter paused.
//  - Load-use (RUN only): ex_mem_read & ex_rt_addr!=0 & (ex_rt_addr==id_rs_addr | (id_uses_rt &
//    ex_rt_addr==id_rt_addr)) -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle; no
//    state change (hazard clears as load advances).
//  - Default (no event): pc_write=ifid_write=1, others 0.
//  - Forwarding (combinational, all states): fwd_a=10 if mem_reg_write & mem_dst_addr!=0 &
//    mem_dst_addr==ex_rs_addr; else 01 if wb_reg_write & wb_dst_addr!=0 & wb_dst_addr==ex_rs_addr;
//    else 00. fwd_b identical with ex_rt_addr. EX/MEM wins when both match. $zero never forwarded.
//  - Counters saturate at all-ones, never wrap.
// CONFIGURATION
//  - HAZ_PERF_CNT_EN defined: stall_cnt +1 each cycle pc_write=0 (reset excluded); flush_cnt +1 per
//    accepted ex_branch_tkn. Not defined: counter regs absent, stall_cnt=flush_cnt tied to 0.
// TESTING
//  - lw $2 in EX, ID add uses $2 as Rs -> one cycle pc_write=0, idex_bubble=1; next cycle pc_write=1.
//  - lw $0 in EX, ID reads $0 -> no stall; ID sw with id_uses_rt=0, Rt match -> no stall.
//  - beq taken, FLUSH_DEPTH=2 -> ifid_flush=idex_bubble=1 for 2 cycles, state RUN after; flush_cnt=1.
//  - dmem_req=1, dmem_ready after 3 cycles -> exmem_hold=1 for 3 cycles, released on ready cycle.
//  - dmem_ready never, MEM_TIMEOUT=4 -> after 4 wait cycles mem_err=1 (sticky), RUN; rst_n=0 clears.
//  - EX/MEM and MEM/WB both write $5, ex_rs=$5 -> fwd_a=10; only MEM/WB -> 01; rst_n=0 mid-FLUSH -> RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard, stall and flush sequencer for the 5-stage pipeline, plus the EX-stage
//   forwarding selects. Handles load-use stalls, data-memory wait states and
//   taken-branch flushes.
//   Optional feature macro: HAZ_PERF_CNT_EN. When it is defined, the stall_cnt and
//   flush_cnt performance counters are built. When it is not defined, both outputs
//   are tied to zero.
//
//   Handshake: a data-memory access completes in any cycle where dmem_req=1 and
//   dmem_ready=1. A cycle with dmem_req=1 and dmem_ready=0 is a wait state. During a
//   wait state PC and IF/ID are frozen and EX/MEM plus MEM/WB are held. The freeze is
//   released in the same cycle that dmem_ready rises.
//
//   Debug: dbg_state_o exposes the FSM state (RUN=0, MEM_WAIT=1, FLUSH=2).
module pipe_hazard_ctrl #(
   parameter int unsigned FLUSH_DEPTH = 2,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs_addr,
   input  logic [4:0]       id_rt_addr,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rs_addr,
   input  logic [4:0]       ex_rt_addr,
   input  logic             ex_branch_tkn,
   input  logic             mem_reg_write,
   input  logic [4:0]       mem_dst_addr,
   input  logic             wb_reg_write,
   input  logic [4:0]       wb_dst_addr,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_hold,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_e;

   // Bubbles still owed after the branch cycle itself has already flushed.
   localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_DEPTH - 1);
   localparam bit         FLUSH_MULTI = (FLUSH_DEPTH > 1);
   localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

   state_e     state_q;
   logic [7:0] wait_cnt_q;
   logic [2:0] flush_left_q;
   logic       mem_err_q;

   logic mem_stall;
   logic load_use;

   // Raw hazard events, evaluated before any priority is applied.
   always_comb begin
      mem_stall = dmem_req & ~dmem_ready;
      load_use  = ex_mem_read & (ex_rt_addr != 5'd0) &
                  ((ex_rt_addr == id_rs_addr) |
                   (id_uses_rt & (ex_rt_addr == id_rt_addr)));
   end

   // Pipeline control decode from the current state and inputs; reset overrides all.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_hold  = 1'b0;
      if (!rst_n) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (mem_stall) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  exmem_hold = 1'b1;
               end else if (ex_branch_tkn) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               // The ready cycle releases the freeze immediately.
               if (!dmem_ready) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  exmem_hold = 1'b1;
               end
            end
            ST_FLUSH: begin
               // A memory wait has priority over the remaining bubbles, which resume afterwards.
               if (mem_stall) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  exmem_hold = 1'b1;
               end else begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end
            end
            default: begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
            end
         endcase
      end
   end

   // EX-stage forwarding selects: EX/MEM beats MEM/WB, and $zero is never forwarded.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (rst_n) begin
         if (mem_reg_write && (mem_dst_addr != 5'd0) && (mem_dst_addr == ex_rs_addr)) begin
            fwd_a = 2'b10;
         end else if (wb_reg_write && (wb_dst_addr != 5'd0) && (wb_dst_addr == ex_rs_addr)) begin
            fwd_a = 2'b01;
         end
         if (mem_reg_write && (mem_dst_addr != 5'd0) && (mem_dst_addr == ex_rt_addr)) begin
            fwd_b = 2'b10;
         end else if (wb_reg_write && (wb_dst_addr != 5'd0) && (wb_dst_addr == ex_rt_addr)) begin
            fwd_b = 2'b01;
         end
      end
   end

   // Sequencer FSM with the wait-timeout counter, the flush down-counter and the sticky error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         wait_cnt_q   <= 8'd0;
         flush_left_q <= 3'd0;
         mem_err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (mem_stall) begin
                  state_q    <= ST_MEM_WAIT;
                  wait_cnt_q <= 8'd1;
               end else if (ex_branch_tkn && FLUSH_MULTI) begin
                  state_q      <= ST_FLUSH;
                  flush_left_q <= FLUSH_INIT;
               end
            end
            ST_MEM_WAIT: begin
               if (dmem_ready) begin
                  state_q <= ST_RUN;
               end else if (wait_cnt_q >= TIMEOUT_LIM) begin
                  mem_err_q <= 1'b1;
                  state_q   <= ST_RUN;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            ST_FLUSH: begin
               if (!mem_stall) begin
                  flush_left_q <= flush_left_q - 3'd1;
                  if (flush_left_q <= 3'd1) begin
                     state_q <= ST_RUN;
                  end
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign mem_err     = mem_err_q;
   assign dbg_state_o = state_q;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;
   logic             branch_acc;

   // A branch is accepted only in RUN when no memory wait pre-empts it.
   assign branch_acc = (state_q == ST_RUN) & ~mem_stall & ex_branch_tkn;

   // Saturating performance counters; the forced stall during reset is not counted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (branch_acc && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. It has three parts:
//   - A behavioural model that tracks the pipeline mode (normal, waiting or bubbling)
//     using plain counters.
//   - A compare process that checks every DUT output against the model on each
//     falling clock edge.
//   - Hand-computed literal pins. Each pin is tied to a specific cycle and anchors
//     the model to known-good values.
module tb_pipe_hazard_ctrl;

   localparam int FLUSH_DEPTH = 2;
   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 32;
`ifdef HAZ_PERF_CNT_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   // Field ids used as keys for the literal pins.
   localparam int F_PC = 0, F_IW = 1, F_FL = 2, F_BB = 3, F_HD = 4, F_FA = 5,
                  F_FB = 6, F_ER = 7, F_ST = 8, F_FC = 9, F_SC = 10;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, mem_dst_addr, wb_dst_addr;
   logic             id_uses_rt, ex_mem_read, ex_branch_tkn, mem_reg_write, wb_reg_write;
   logic             dmem_req, dmem_ready;
   logic             pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, mem_err;
   logic [1:0]       fwd_a, fwd_b, dbg_state_o;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(
      .FLUSH_DEPTH(FLUSH_DEPTH), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
      .ex_branch_tkn(ex_branch_tkn), .mem_reg_write(mem_reg_write),
      .mem_dst_addr(mem_dst_addr), .wb_reg_write(wb_reg_write), .wb_dst_addr(wb_dst_addr),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .exmem_hold(exmem_hold), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .dbg_state_o(dbg_state_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- model state ----------------
   // m_mode: 0 normal, 1 waiting on memory, 2 bubbling after a branch
   int          m_mode    = 0;
   int          m_waited  = 0;
   int          m_left    = 0;
   bit          m_err     = 1'b0;
   longint      m_stalls  = 0;
   longint      m_flushes = 0;
   bit          m_known   = 1'b0;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          pins[int];

   function automatic bit mem_waiting();
      return dmem_req && !dmem_ready;
   endfunction

   function automatic bit hazard_lu();
      if (!ex_mem_read || ex_rt_addr == 5'd0) return 1'b0;
      if (ex_rt_addr == id_rs_addr) return 1'b1;
      return id_uses_rt && (ex_rt_addr == id_rt_addr);
   endfunction

   // Expected control outputs, packed as {pc, ifid_w, flush, bubble, hold}.
   function automatic logic [4:0] exp_ctrl();
      if (!rst_n) return 5'b00110;
      if (m_mode == 1) return dmem_ready ? 5'b11000 : 5'b00001;
      if (m_mode == 2) return mem_waiting() ? 5'b00001 : 5'b11110;
      if (mem_waiting()) return 5'b00001;
      if (ex_branch_tkn) return 5'b11110;
      if (hazard_lu()) return 5'b00010;
      return 5'b11000;
   endfunction

   function automatic logic [1:0] exp_fwd(logic [4:0] src);
      if (!rst_n || src == 5'd0) return 2'b00;
      if (mem_reg_write && mem_dst_addr == src) return 2'b10;
      if (wb_reg_write && wb_dst_addr == src) return 2'b01;
      return 2'b00;
   endfunction

   // Model advance on each rising edge.
   always @(posedge clk) begin
      logic [4:0] c;
      if (!rst_n) begin
         m_mode = 0; m_waited = 0; m_left = 0; m_err = 1'b0;
         m_stalls = 0; m_flushes = 0; m_known = 1'b1;
      end else begin
         c = exp_ctrl();
         if (!c[4]) m_stalls = m_stalls + 1;
         if (m_mode == 0) begin
            if (mem_waiting()) begin
               m_mode = 1; m_waited = 0;
            end else if (ex_branch_tkn) begin
               m_flushes = m_flushes + 1;
               m_left = FLUSH_DEPTH - 1;
               if (m_left > 0) m_mode = 2;
            end
         end else if (m_mode == 1) begin
            m_waited = m_waited + 1;
            if (dmem_ready) m_mode = 0;
            else if (m_waited == MEM_TIMEOUT) begin
               m_err = 1'b1; m_mode = 0;
            end
         end else begin
            if (!mem_waiting()) begin
               m_left = m_left - 1;
               if (m_left == 0) m_mode = 0;
            end
         end
      end
   end

   function automatic longint act_field(int f);
      case (f)
         F_PC: return longint'(pc_write);
         F_IW: return longint'(ifid_write);
         F_FL: return longint'(ifid_flush);
         F_BB: return longint'(idex_bubble);
         F_HD: return longint'(exmem_hold);
         F_FA: return longint'(fwd_a);
         F_FB: return longint'(fwd_b);
         F_ER: return longint'(mem_err);
         F_ST: return longint'(dbg_state_o);
         F_FC: return longint'(flush_cnt);
         default: return longint'(stall_cnt);
      endcase
   endfunction

   task automatic chk(string name, longint act, longint exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic [4:0] c;
      if (m_known) begin
         c = exp_ctrl();
         chk("pc_write",    longint'(pc_write),    longint'(c[4]));
         chk("ifid_write",  longint'(ifid_write),  longint'(c[3]));
         chk("ifid_flush",  longint'(ifid_flush),  longint'(c[2]));
         chk("idex_bubble", longint'(idex_bubble), longint'(c[1]));
         chk("exmem_hold",  longint'(exmem_hold),  longint'(c[0]));
         chk("fwd_a",       longint'(fwd_a),       longint'(exp_fwd(ex_rs_addr)));
         chk("fwd_b",       longint'(fwd_b),       longint'(exp_fwd(ex_rt_addr)));
         chk("mem_err",     longint'(mem_err),     longint'(m_err));
         chk("state",       longint'(dbg_state_o), longint'(m_mode));
         chk("flush_cnt",   longint'(flush_cnt),   PERF ? m_flushes : 0);
         chk("stall_cnt",   longint'(stall_cnt),   PERF ? m_stalls : 0);
         for (int f = 0; f <= F_SC; f++) begin
            if (pins.exists(cyc * 16 + f)) begin
               chk($sformatf("pin_f%0d", f), act_field(f), longint'(pins[cyc * 16 + f]));
            end
         end
      end
      cyc = cyc + 1;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_uses_rt = 1'b0;
      ex_mem_read = 1'b0; ex_rs_addr = 5'd0; ex_rt_addr = 5'd0; ex_branch_tkn = 1'b0;
      mem_reg_write = 1'b0; mem_dst_addr = 5'd0; wb_reg_write = 1'b0; wb_dst_addr = 5'd0;
      dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic pin(int f, int v);
      pins[cyc * 16 + f] = v;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      set_idle();
      rst_n = 1'b0;
      // Reset: outputs are forced.
      tick(); pin(F_PC, 0); pin(F_IW, 0); pin(F_FL, 1); pin(F_BB, 1); pin(F_HD, 0);
      tick(); pin(F_ST, 0); pin(F_ER, 0); pin(F_SC, 0);
      tick(); rst_n = 1'b1; pin(F_PC, 1); pin(F_FL, 0); pin(F_BB, 0);

      // lw $2 in EX, add in ID reads $2 as Rs: one stall cycle.
      tick(); ex_mem_read = 1'b1; ex_rt_addr = 5'd2; id_rs_addr = 5'd2;
      pin(F_PC, 0); pin(F_IW, 0); pin(F_BB, 1);
      tick(); set_idle(); pin(F_PC, 1); pin(F_BB, 0);

      // lw $0 with ID reading $0: no stall.
      tick(); ex_mem_read = 1'b1; ex_rt_addr = 5'd0; id_rs_addr = 5'd0; id_rt_addr = 5'd0;
      id_uses_rt = 1'b1; pin(F_PC, 1);
      // sw in ID (Rt not read) matching the Rt of the load: no stall.
      tick(); ex_rt_addr = 5'd7; id_rs_addr = 5'd3; id_rt_addr = 5'd7; id_uses_rt = 1'b0;
      pin(F_PC, 1); pin(F_BB, 0);
      // The same instruction now reading Rt: stall.
      tick(); id_uses_rt = 1'b1; pin(F_PC, 0); pin(F_BB, 1);
      tick(); set_idle();

      // Taken branch: two bubble cycles, then RUN.
      tick(); ex_branch_tkn = 1'b1; pin(F_FL, 1); pin(F_BB, 1); pin(F_PC, 1);
      tick(); ex_branch_tkn = 1'b1; pin(F_FL, 1); pin(F_BB, 1); pin(F_ST, 2);
      tick(); ex_branch_tkn = 1'b0; pin(F_FL, 0); pin(F_ST, 0); pin(F_FC, PERF);

      // Memory ready after three wait cycles.
      tick(); dmem_req = 1'b1; pin(F_HD, 1); pin(F_PC, 0); pin(F_ST, 0);
      tick(); pin(F_HD, 1); pin(F_ST, 1);
      tick(); pin(F_HD, 1);
      tick(); dmem_ready = 1'b1; pin(F_HD, 0); pin(F_PC, 1); pin(F_ST, 1);
      tick(); set_idle(); pin(F_ST, 0);

      // Forwarding patterns.
      tick(); mem_reg_write = 1'b1; mem_dst_addr = 5'd5; wb_reg_write = 1'b1; wb_dst_addr = 5'd5;
      ex_rs_addr = 5'd5; pin(F_FA, 2);
      tick(); mem_reg_write = 1'b0; pin(F_FA, 1);
      tick(); ex_rs_addr = 5'd0; wb_dst_addr = 5'd0; mem_reg_write = 1'b1; mem_dst_addr = 5'd0;
      pin(F_FA, 0);
      tick(); ex_rt_addr = 5'd9; wb_dst_addr = 5'd9; mem_dst_addr = 5'd3; pin(F_FB, 1);
      tick(); mem_dst_addr = 5'd9; pin(F_FB, 2);
      tick(); set_idle();

      // Same-cycle priority: memory wait beats branch and load-use.
      tick(); dmem_req = 1'b1; ex_branch_tkn = 1'b1; ex_mem_read = 1'b1; ex_rt_addr = 5'd4;
      id_rs_addr = 5'd4; pin(F_HD, 1); pin(F_FL, 0); pin(F_BB, 0); pin(F_PC, 0);
      tick(); set_idle(); dmem_req = 1'b1; dmem_ready = 1'b1; pin(F_PC, 1); pin(F_ST, 1);
      // Branch beats load-use.
      tick(); set_idle(); ex_branch_tkn = 1'b1; ex_mem_read = 1'b1; ex_rt_addr = 5'd4;
      id_rs_addr = 5'd4; pin(F_FL, 1); pin(F_PC, 1); pin(F_IW, 1);
      // A memory wait inside FLUSH freezes the pipe and pauses the bubble count.
      tick(); set_idle(); dmem_req = 1'b1; pin(F_HD, 1); pin(F_FL, 0); pin(F_ST, 2);
      tick(); dmem_ready = 1'b1; pin(F_HD, 0); pin(F_FL, 1); pin(F_ST, 2);
      tick(); set_idle(); pin(F_ST, 0); pin(F_FL, 0);

      // Timeout: ready never arrives.
      tick(); dmem_req = 1'b1; pin(F_HD, 1); pin(F_ST, 0);
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         tick(); pin(F_HD, 1); pin(F_ST, 1); pin(F_ER, 0);
      end
      tick(); set_idle(); pin(F_ER, 1); pin(F_ST, 0); pin(F_PC, 1);
      tick(); pin(F_ER, 1);
      tick(); rst_n = 1'b0;
      tick(); rst_n = 1'b1; pin(F_ER, 0); pin(F_FC, 0); pin(F_SC, 0);

      // Reset in the middle of FLUSH returns the sequencer to RUN.
      tick(); ex_branch_tkn = 1'b1;
      tick(); ex_branch_tkn = 1'b0; pin(F_ST, 2);
      tick(); rst_n = 1'b0; pin(F_PC, 0); pin(F_FL, 1);
      tick(); rst_n = 1'b1; pin(F_ST, 0); pin(F_FL, 0); pin(F_PC, 1);

      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
